// File: rtl/fetch_queue.sv
// Instruction-fetch front end: sequential word fetch, 1-cycle imem, {pc,data} FIFO to decode.
// Optional FETCH_QUEUE_STATS_EN adds saturating starve/redirect counters.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
`ifdef FETCH_QUEUE_STATS_EN
    ,
    output logic [31:0] stat_starve,
    output logic [31:0] stat_redirects
`endif
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] C_DEPTH = (AW + 1)'(DEPTH);

    logic [31:0]   r_fetch_pc;
    logic          r_inflight;
    logic [31:0]   r_inflight_pc;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;
    logic [31:0]   r_mem_pc   [DEPTH];
    logic [31:0]   r_mem_data [DEPTH];

    logic          w_pop_raw;
    logic          w_pop;
    logic          w_push;
    logic [AW:0]   w_occ;

    assign inst_valid = (r_count != '0);
    assign inst_data  = inst_valid ? r_mem_data[r_rd_ptr] : 32'h0;
    assign inst_pc    = inst_valid ? r_mem_pc[r_rd_ptr]   : 32'h0;

    assign w_pop_raw = inst_valid && inst_ready;
    assign w_pop     = w_pop_raw && !redirect_valid;
    assign w_push    = r_inflight && !redirect_valid;

    // Credit: buffered + in-flight entries must leave room for the new response.
    assign w_occ     = r_count + (AW + 1)'(r_inflight) - (AW + 1)'(w_pop_raw);
    assign imem_req  = rst_n && !redirect_valid && (w_occ < C_DEPTH);
    assign imem_addr = rst_n ? r_fetch_pc : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= 32'h0;
        end else if (redirect_valid) begin
            r_fetch_pc    <= {redirect_pc[31:2], 2'b00};
            r_inflight    <= 1'b0;
        end else if (imem_req) begin
            r_fetch_pc    <= r_fetch_pc + 32'd4;
            r_inflight    <= 1'b1;
            r_inflight_pc <= r_fetch_pc;
        end else begin
            r_inflight    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (redirect_valid) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; r_count gates visibility of stale entries.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]   <= r_inflight_pc;
            r_mem_data[r_wr_ptr] <= imem_rdata;
        end
    end

`ifdef FETCH_QUEUE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_starve    <= 32'h0;
            stat_redirects <= 32'h0;
        end else begin
            if (inst_ready && !inst_valid && (stat_starve != 32'hFFFF_FFFF))
                stat_starve <= stat_starve + 32'd1;
            if (redirect_valid && (stat_redirects != 32'hFFFF_FFFF))
                stat_redirects <= stat_redirects + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue; imem model returns addr ^ 32'hA5A5_0000 one cycle later.
module tb_fetch_queue;

    localparam logic [31:0] XK = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b1;
`ifdef FETCH_QUEUE_STATS_EN
    logic [31:0] stat_starve;
    logic [31:0] stat_redirects;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] r_last_addr = 32'h0;

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
`ifdef FETCH_QUEUE_STATS_EN
        ,
        .stat_starve    (stat_starve),
        .stat_redirects (stat_redirects)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) r_last_addr <= imem_addr;
    assign imem_rdata = r_last_addr ^ XK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_req"},   {31'b0, imem_req},   32'h0);
        check({tag, "_addr"},  imem_addr,           32'h0);
        check({tag, "_valid"}, {31'b0, inst_valid}, 32'h0);
        check({tag, "_data"},  inst_data,           32'h0);
        check({tag, "_pc"},    inst_pc,             32'h0);
    endtask

    // Leaves the bench 1ns after the release negedge (cycle N0).
    task automatic do_reset(input logic ready);
        @(negedge clk);
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        inst_ready = ready;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    // Overflow watchdog: a push into a full FIFO without a matching pop.
    always @(negedge clk) begin
        if (rst_n && dut.w_push)
            check("no_overflow", {31'b0, (dut.r_count == 3'd4) && !dut.w_pop}, 32'h0);
    end

    initial begin
        // Reset state and basic streaming
        @(negedge clk);
        @(negedge clk);
        #1;
        check_zero_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t1_req0",   {31'b0, imem_req},   32'h1);
        check("t1_addr0",  imem_addr,           32'h0);
        check("t1_valid0", {31'b0, inst_valid}, 32'h0);
        for (int i = 1; i <= 7; i++) begin
            next_cycle();
            check("t1_addr", imem_addr, 32'(4 * i));
            if (i == 1) begin
                check("t1_valid1", {31'b0, inst_valid}, 32'h0);
            end else begin
                check("t1_valid", {31'b0, inst_valid}, 32'h1);
                check("t1_pc",    inst_pc,   32'(4 * (i - 2)));
                check("t1_data",  inst_data, 32'(4 * (i - 2)) ^ XK);
            end
        end

        // Backpressure: fill to 4, hold, then drain
        do_reset(1'b0);
        for (int i = 1; i <= 3; i++) begin
            next_cycle();
            check("t2_req",  {31'b0, imem_req}, 32'h1);
            check("t2_addr", imem_addr,         32'(4 * i));
        end
        next_cycle();
        check("t2_req_stop", {31'b0, imem_req}, 32'h0);
        for (int i = 5; i <= 10; i++) begin
            next_cycle();
            check("t2_hold_req",   {31'b0, imem_req},   32'h0);
            check("t2_hold_valid", {31'b0, inst_valid}, 32'h1);
            check("t2_hold_pc",    inst_pc,             32'h0);
            check("t2_hold_data",  inst_data,           XK);
        end
        inst_ready = 1'b1;
        #1;
        check("t2_req_resume",  {31'b0, imem_req}, 32'h1);
        check("t2_addr_resume", imem_addr,         32'h10);
        for (int i = 1; i <= 4; i++) begin
            next_cycle();
            check("t2_drain_valid", {31'b0, inst_valid}, 32'h1);
            check("t2_drain_pc",    inst_pc,             32'(4 * i));
            check("t2_drain_data",  inst_data,           32'(4 * i) ^ XK);
        end

        // Redirect with 3 buffered entries and one in flight
        do_reset(1'b0);
        for (int i = 1; i <= 4; i++) next_cycle();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_1002;
        #1;
        check("t3_req_during", {31'b0, imem_req}, 32'h0);
        next_cycle();
        redirect_valid = 1'b0;
        inst_ready = 1'b1;
        #1;
        check("t3_req",    {31'b0, imem_req},   32'h1);
        check("t3_addr",   imem_addr,           32'h0000_1000);
        check("t3_valid0", {31'b0, inst_valid}, 32'h0);
        next_cycle();
        check("t3_valid1", {31'b0, inst_valid}, 32'h0);
        next_cycle();
        check("t3_valid2", {31'b0, inst_valid}, 32'h1);
        check("t3_pc2",    inst_pc,             32'h0000_1000);
        check("t3_data2",  inst_data,           32'h0000_1000 ^ XK);
        next_cycle();
        check("t3_pc3",    inst_pc,             32'h0000_1004);

        // Back-to-back redirects, last wins, then address wrap
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_2000;
        next_cycle();
        redirect_pc = 32'hFFFF_FFF8;
        next_cycle();
        redirect_valid = 1'b0;
        #1;
        check("t4_addr0",  imem_addr,           32'hFFFF_FFF8);
        check("t4_valid0", {31'b0, inst_valid}, 32'h0);
        next_cycle();
        check("t4_addr1",  imem_addr,           32'hFFFF_FFFC);
        next_cycle();
        check("t4_addr2",  imem_addr,           32'h0000_0000);
        check("t4_pc2",    inst_pc,             32'hFFFF_FFF8);
        check("t4_data2",  inst_data,           32'hFFFF_FFF8 ^ XK);
        next_cycle();
        check("t4_addr3",  imem_addr,           32'h0000_0004);
        check("t4_pc3",    inst_pc,             32'hFFFF_FFFC);
        next_cycle();
        check("t4_pc4",    inst_pc,             32'h0000_0000);
        check("t4_valid4", {31'b0, inst_valid}, 32'h1);

        // Asynchronous reset mid-stream
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("t5_async");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t5_req",    {31'b0, imem_req},   32'h1);
        check("t5_addr",   imem_addr,           32'h0);
        check("t5_valid0", {31'b0, inst_valid}, 32'h0);
        next_cycle();
        check("t5_addr1",  imem_addr,           32'h4);
        next_cycle();
        check("t5_valid2", {31'b0, inst_valid}, 32'h1);
        check("t5_pc2",    inst_pc,             32'h0);

`ifdef FETCH_QUEUE_STATS_EN
        // 3 redirect cycles, 5 starved cycles
        do_reset(1'b1);
        check("t6_starve_rst", stat_starve,    32'h0);
        check("t6_redir_rst",  stat_redirects, 32'h0);
        next_cycle();
        next_cycle();
        inst_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0100;
        next_cycle();
        inst_ready = 1'b1;
        next_cycle();
        inst_ready = 1'b0;
        next_cycle();
        redirect_valid = 1'b0;
        inst_ready = 1'b1;
        next_cycle();
        next_cycle();
        check("t6_starve", stat_starve,    32'd5);
        check("t6_redir",  stat_redirects, 32'd3);
        inst_ready = 1'b0;
`endif

        next_cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch front end between the instruction memory port and the decode stage of the five-stage ARM pipeline.
- Generates sequential word fetch addresses and issues requests to a synchronous-read imem with 1-cycle latency.
- Buffers returned instructions with their PCs in a small FIFO and hands them to decode over a valid/ready handshake.
- Handles redirects (branch/exception) by flushing buffered and in-flight fetches.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- redirect_valid  input  1  flush and restart fetch at redirect_pc.
- redirect_pc  input  32  new fetch address; bits [1:0] ignored and forced to 0.
- imem_req  output  1  fetch request this cycle.
- imem_addr  output  32  word-aligned fetch address; valid when imem_req=1.
- imem_rdata  input  32  instruction word; valid in the cycle after an imem_req cycle.
- inst_valid  output  1  FIFO head holds a valid instruction.
- inst_data  output  32  head instruction word.
- inst_pc  output  32  address of the head instruction.
- inst_ready  input  1  decode accepts the head this cycle.

Behaviour:
- Reset (asynchronous assert, applies at any time including mid-fetch or mid-flush):
  - fetch_pc = RESET_PC; FIFO empty (count 0, pointers 0); inflight = 0; inflight_pc = 0.
  - Outputs: imem_req = 0, imem_addr = 0, inst_valid = 0, inst_data = 0, inst_pc = 0.
  - First imem_req occurs in the first cycle after rst_n deasserts.
- State:
  - fetch_pc (32 b).
  - inflight flag (1 b): response due next cycle.
  - inflight_pc (32 b).
  - FIFO of {pc, data}: rd_ptr, wr_ptr, count (0..DEPTH).
- Issue rule (combinational):
  - imem_req = !redirect_valid && (count + inflight − pop) < DEPTH, where pop = inst_valid && inst_ready.
  - imem_addr = fetch_pc.
  - On an issue edge: fetch_pc += 4 (wraps modulo 2^32, so 0xFFFF_FFFC → 0x0000_0000); inflight <= 1; inflight_pc <= fetch_pc. Otherwise inflight <= 0.
- Response:
  - When inflight = 1 and no redirect this cycle, {inflight_pc, imem_rdata} is pushed at the edge.
  - The credit rule guarantees the push never hits a full FIFO. Overflow is a design error; the bench asserts it never occurs.
- Pop:
  - inst_valid = (count != 0); head entry is driven combinationally from the FIFO.
  - On inst_valid && inst_ready: rd_ptr advances.
  - Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- Redirect (highest priority, single cycle):
  - FIFO cleared (count = 0, rd_ptr = wr_ptr = 0).
  - Any inflight response arriving this cycle is discarded; inflight <= 0.
  - Pop in the same cycle is ignored.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}; imem_req = 0 this cycle.
  - Consecutive redirect cycles: the last one wins.
- Latency:
  - Redirect edge E0 → imem_req with the new address in the cycle after E0.
  - Data captured at E2; inst_valid = 1 after E2.
  - Steady-state throughput 1 instruction/cycle with inst_ready held high.
- Backpressure: inst_ready = 0 holds the head stable (inst_data and inst_pc unchanged) until accepted.

Optional Feature:
- Macro FETCH_QUEUE_STATS_EN.
- Defined:
  - Adds outputs stat_starve (32 b) and stat_redirects (32 b).
  - Both counters reset to 0 and saturate at 32'hFFFF_FFFF.
  - stat_starve increments each cycle with inst_ready = 1 && inst_valid = 0 && rst_n = 1.
  - stat_redirects increments each redirect_valid cycle.
- Undefined: ports and counters are absent; functional behaviour is otherwise identical.

Test Plan:
- Reset release, RESET_PC = 0, inst_ready = 1, imem returns addr^32'hA5A5_0000:
  - imem_addr sequence 0, 4, 8, …
  - First inst_valid 2 cycles after release with inst_pc = 0, inst_data = 32'hA5A5_0000.
  - Then one instruction per cycle.
- inst_ready = 0 for 10 cycles after reset:
  - imem_req drops once count + inflight = 4.
  - Exactly 4 entries are held with PCs 0, 4, 8, C and the head is stable.
  - Raising inst_ready drains PCs 0, 4, 8, C, 10 in order with no gaps or duplicates.
- Redirect to 32'h0000_1002 while FIFO holds 3 entries and a fetch is in flight:
  - Next request address is 32'h0000_1000.
  - inst_valid = 0 for the following 2 cycles, then inst_pc = 32'h0000_1000.
  - No stale PC ever appears at the output.
- Redirect to 32'hFFFF_FFF8: the fetch sequence FFFF_FFF8, FFFF_FFFC, 0000_0000 wraps correctly.
- Assert rst_n low mid-stream for one cycle, asynchronous to clk:
  - Outputs go to 0 immediately.
  - Fetch restarts at RESET_PC.
- With FETCH_QUEUE_STATS_EN: 3 redirects plus 5 starved cycles gives stat_redirects = 3 and stat_starve = 5.
